// File: rtl/bm_direct_reorder.sv
// ---------------------------------------------------------------------------
// bm_direct_reorder
//
// Purpose
//   Reorder buffer that sits between the direct-lighting calculator and the
//   pixel writer. Results come in out of order, tagged by rayID. Each one is
//   parked in a RAM slot indexed by its rayID. A retire pointer (head) then
//   emits the slots strictly in rayID order, wrapping 2**RID_W-1 -> 0.
//
// Ports
//   clk                       single clock, rising edge
//   rst                       synchronous, active-high reset
//   calc_direct_to_BM_data    packed {rayID[RID_W-1:0], red, green, blue};
//                             each color component is an IEEE-754 single
//   calc_direct_to_BM_valid   upstream data valid
//   calc_direct_to_BM_stall   upstream must hold data/valid while high
//                             (the target slot is still occupied)
//   pixel_rayID               rayID of the retired entry
//   pixel_color               {red, green, blue} of the retired entry
//   pixel_valid               output data valid
//   pixel_stall               downstream back-pressure
//
// Configuration
//   BM_CLAMP_EN  When defined, each color component is clamped to [0.0, 1.0]
//                as the output register loads. Negative values become 0.0,
//                and values above 1.0 become 1.0. Timing is the same either
//                way.
// ---------------------------------------------------------------------------
module bm_direct_reorder #(
   parameter int RID_W = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [RID_W+95:0]  calc_direct_to_BM_data,
   input  logic               calc_direct_to_BM_valid,
   output logic               calc_direct_to_BM_stall,
   output logic [RID_W-1:0]   pixel_rayID,
   output logic [95:0]        pixel_color,
   output logic               pixel_valid,
   input  logic               pixel_stall
);

   localparam int DEPTH   = 2**RID_W;
   localparam int COLOR_W = 96;

`ifdef BM_CLAMP_EN
   // Clamp one IEEE-754 single to [0.0, 1.0] by comparing raw bits. For
   // positive floats, unsigned bit order matches numeric order.
   function automatic logic [31:0] clamp_comp(input logic [31:0] c);
      logic [31:0] r;
      if (c[31])
         r = 32'h0000_0000;
      else if (c > 32'h3F80_0000)
         r = 32'h3F80_0000;
      else
         r = c;
      return r;
   endfunction
`endif

   // Shaping applied to the color as it enters the output register.
   function automatic logic [COLOR_W-1:0] shape_color(input logic [COLOR_W-1:0] c);
`ifdef BM_CLAMP_EN
      return {clamp_comp(c[95:64]), clamp_comp(c[63:32]), clamp_comp(c[31:0])};
`else
      return c;
`endif
   endfunction

   // Input field split
   logic [RID_W-1:0]   in_rid;
   logic [COLOR_W-1:0] in_color;

   assign in_rid   = calc_direct_to_BM_data[RID_W+95:96];
   assign in_color = calc_direct_to_BM_data[95:0];

   // Slot state
   logic [DEPTH-1:0]   occ;
   logic [RID_W-1:0]   head;
   logic [COLOR_W-1:0] mem [DEPTH];

   // Handshake terms
   logic accept;
   logic out_ready;
   logic rd_issue;
   logic out_load;

   // Read-data stage. It normally empties into the output register on the
   // next edge. It only holds its entry while the output is stalled, which
   // also blocks any new read issue, so it can never be overwritten.
   logic               rd_vld_p1;
   logic [RID_W-1:0]   rd_rid_p1;
   logic [COLOR_W-1:0] rd_color_p1;

   // A free slot is never stalled. An occupied one stalls until it is read.
   assign calc_direct_to_BM_stall = calc_direct_to_BM_valid & occ[in_rid];
   assign accept                  = calc_direct_to_BM_valid & ~occ[in_rid];

   // The output register can take new data when it is empty or draining.
   assign out_ready = ~pixel_valid | ~pixel_stall;

   // occ[head] is the registered bit. An entry written into the head slot
   // this cycle is therefore read no earlier than next cycle.
   assign rd_issue = occ[head] & out_ready;
   assign out_load = rd_vld_p1 & out_ready;

   // ---- stage p0: slot write / RAM read issue ----
   // accept needs ~occ[in_rid] and rd_issue needs occ[head], so the write
   // slot and the read slot can never coincide.
   always_ff @(posedge clk) begin
      if (accept)
         mem[in_rid] <= in_color;
      if (rd_issue) begin
         rd_color_p1 <= mem[head];
         rd_rid_p1   <= head;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ  <= '0;
         head <= '0;
      end else begin
         if (accept)
            occ[in_rid] <= 1'b1;
         if (rd_issue) begin
            occ[head] <= 1'b0;
            head      <= head + 1'b1;
         end
      end
   end

   // ---- stage p1: read data held for the output register ----
   always_ff @(posedge clk) begin
      if (rst)
         rd_vld_p1 <= 1'b0;
      else if (rd_issue)
         rd_vld_p1 <= 1'b1;
      else if (out_load)
         rd_vld_p1 <= 1'b0;
   end

   // ---- stage p2: output register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         pixel_valid <= 1'b0;
         pixel_rayID <= '0;
         pixel_color <= '0;
      end else if (out_load) begin
         pixel_valid <= 1'b1;
         pixel_rayID <= rd_rid_p1;
         pixel_color <= shape_color(rd_color_p1);
      end else if (!pixel_stall) begin
         pixel_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bm_direct_reorder.sv
module tb_bm_direct_reorder;

   localparam int RID_W = 9;
   localparam int DEPTH = 512;

   typedef struct {
      int          rid;
      logic [95:0] color;
   } ent_t;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic [RID_W-1:0] in_rid;
   logic [95:0]      in_color;
   logic             calc_direct_to_BM_stall;
   logic [RID_W-1:0] pixel_rayID;
   logic [95:0]      pixel_color;
   logic             pixel_valid;
   logic             pixel_stall;

   int          checks;
   int          errors;
   int          exp_head;   // next rayID the model expects to see emitted
   int          n_out;
   int          acc_head;
   bit          acc;
   bit          rnd_ps;
   bit          hold;
   logic [8:0]  hold_rid;
   logic [95:0] hold_col;
   ent_t        sb[$];      // accepted entries, oldest first

   bm_direct_reorder #(.RID_W(RID_W)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .calc_direct_to_BM_data  ({in_rid, in_color}),
      .calc_direct_to_BM_valid (in_valid),
      .calc_direct_to_BM_stall (calc_direct_to_BM_stall),
      .pixel_rayID             (pixel_rayID),
      .pixel_color             (pixel_color),
      .pixel_valid             (pixel_valid),
      .pixel_stall             (pixel_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

`ifdef BM_CLAMP_EN
   function automatic logic [31:0] cl1(input logic [31:0] c);
      if (c[31]) return 32'h0;
      if (c > 32'h3F800000) return 32'h3F800000;
      return c;
   endfunction
`endif

   function automatic logic [95:0] exp_col(input logic [95:0] c);
`ifdef BM_CLAMP_EN
      return {cl1(c[95:64]), cl1(c[63:32]), cl1(c[31:0])};
`else
      return c;
`endif
   endfunction

   function automatic bit pending(input int rid);
      foreach (sb[i]) if (sb[i].rid == rid) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [95:0] rc();
      return {$urandom(), $urandom(), $urandom()};
   endfunction

   // One clock cycle. The model is updated at the falling edge, from
   // whatever transfers happen at the following rising edge.
   task automatic tick();
      int idx;
      idx  = -1;
      @(negedge clk);
      acc  = 1'b0;
      hold = 1'b0;
      if (!rst) begin
         if (in_valid) begin
            if (!pending(int'(in_rid)))
               chk("free_slot_stall", calc_direct_to_BM_stall, 0);
            if (!calc_direct_to_BM_stall) begin
               sb.push_back('{int'(in_rid), in_color});
               acc      = 1'b1;
               acc_head = exp_head;
            end
         end
         if (pixel_valid && !pixel_stall) begin
            foreach (sb[i]) if (idx < 0 && sb[i].rid == exp_head % DEPTH) idx = i;
            chk("out_rid", pixel_rayID, exp_head % DEPTH);
            chk("out_known", idx >= 0, 1);
            if (idx >= 0) begin
               chk("out_color", pixel_color, exp_col(sb[idx].color));
               sb.delete(idx);
            end
            exp_head++;
            n_out++;
         end
         if (pixel_valid && pixel_stall) begin
            hold     = 1'b1;
            hold_rid = pixel_rayID;
            hold_col = pixel_color;
         end
      end
      @(posedge clk);
      #1;
      if (hold && !rst) begin
         chk("hold_valid", pixel_valid, 1);
         chk("hold_rid", pixel_rayID, hold_rid);
         chk("hold_color", pixel_color, hold_col);
      end
      if (rnd_ps) pixel_stall = ($urandom_range(0, 3) == 0);
   endtask

   task automatic send(input int rid, input logic [95:0] col);
      in_valid = 1'b1;
      in_rid   = rid[RID_W-1:0];
      in_color = col;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (acc) break;
      end
      chk("send_accepted", acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         if (sb.size() == 0 && !pixel_valid) break;
         tick();
      end
      chk("drain_empty", sb.size(), 0);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      in_rid   = 9'd5;
      in_color = rc();
      tick();
      chk("rst_stall", calc_direct_to_BM_stall, 0);
      chk("rst_valid", pixel_valid, 0);
      chk("rst_rid", pixel_rayID, 0);
      chk("rst_color", pixel_color, 0);
      in_valid = 1'b0;
      tick();
      rst      = 1'b0;
      sb.delete();
      exp_head = 0;
      n_out    = 0;
   endtask

   initial begin
      int          ids[16];
      int          base;
      int          j;
      int          t;
      logic [95:0] expc;
      checks      = 0;
      errors      = 0;
      exp_head    = 0;
      n_out       = 0;
      acc_head    = 0;
      rnd_ps      = 1'b0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_rid      = '0;
      in_color    = '0;
      pixel_stall = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Single entry: output two edges after the accept.
      send(0, {32'h3F800000, 32'h0, 32'h0});
      chk("lat_e0_valid", pixel_valid, 0);
      tick();
      chk("lat_e1_valid", pixel_valid, 0);
      tick();
      chk("lat_e2_valid", pixel_valid, 1);
      chk("lat_e2_rid", pixel_rayID, 0);
      chk("lat_e2_red", pixel_color[95:64], 32'h3F800000);
      drain();

      // Leave rayID 3 parked (head is 1), then reset: it must be discarded.
      send(3, rc());
      tick();
      tick();
      do_reset();

      // 2,1,0 in -> 0,1,2 out on consecutive cycles.
      send(2, rc());
      send(1, rc());
      send(0, rc());
      tick();
      chk("ord_e1_valid", pixel_valid, 0);
      tick();
      chk("ord_e2_rid", pixel_rayID, 0);
      tick();
      chk("ord_e3_valid", pixel_valid, 1);
      chk("ord_e3_rid", pixel_rayID, 1);
      tick();
      chk("ord_e4_valid", pixel_valid, 1);
      chk("ord_e4_rid", pixel_rayID, 2);
      tick();
      chk("ord_e5_valid", pixel_valid, 0);
      drain();
      chk("ord_count", n_out, 3);

      // Back-pressure: hold rayID 0 for 10 cycles, then 1..3 back-to-back.
      do_reset();
      pixel_stall = 1'b1;
      for (int r = 0; r < 4; r++) send(r, rc());
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold_valid", pixel_valid, 1);
         chk("bp_hold_rid", pixel_rayID, 0);
      end
      pixel_stall = 1'b0;
      for (int r = 1; r < 4; r++) begin
         tick();
         chk("bp_b2b_valid", pixel_valid, 1);
         chk("bp_b2b_rid", pixel_rayID, r);
      end
      tick();
      chk("bp_end_valid", pixel_valid, 0);
      chk("bp_count", n_out, 4);

      // Duplicate rayID 5 must stall until the first 5 retires, then be
      // accepted. The stream then continues through the wrap 511 -> 0.
      do_reset();
      pixel_stall = 1'b1;
      send(5, rc());
      for (int r = 0; r < 5; r++) send(r, rc());
      in_valid = 1'b1;
      in_rid   = 9'd5;
      in_color = rc();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("dup5_stall", calc_direct_to_BM_stall, 1);
      end
      pixel_stall = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (acc) break;
      end
      chk("dup5_accepted", acc, 1);
      chk("dup5_after_retire", acc_head >= 4, 1);
      in_valid = 1'b0;
      rnd_ps   = 1'b1;
      for (int r = 6; r < 512; r++) send(r, rc());
      for (int r = 0; r < 5; r++) send(r, rc());
      drain();
      chk("wrap_count", n_out, 518);
      chk("wrap_head", exp_head % DEPTH, 6);
      rnd_ps      = 1'b0;
      pixel_stall = 1'b0;

      // Clamp behaviour with (3.0, -1.0, 0.5).
      do_reset();
      send(0, {32'h40400000, 32'hBF800000, 32'h3F000000});
      tick();
      tick();
`ifdef BM_CLAMP_EN
      expc = {32'h3F800000, 32'h00000000, 32'h3F000000};
`else
      expc = {32'h40400000, 32'hBF800000, 32'h3F000000};
`endif
      chk("clamp_valid", pixel_valid, 1);
      chk("clamp_color", pixel_color, expc);
      drain();

      // Random windows: 16 consecutive rayIDs sent shuffled, with random gaps
      // and random back-pressure.
      rnd_ps = 1'b1;
      for (int w = 0; w < 4; w++) begin
         base = exp_head;
         for (int k = 0; k < 16; k++) ids[k] = (base + k) % DEPTH;
         for (int k = 15; k > 0; k--) begin
            j      = $urandom_range(0, k);
            t      = ids[k];
            ids[k] = ids[j];
            ids[j] = t;
         end
         for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 2) == 0) tick();
            send(ids[k], rc());
         end
         drain();
      end
      chk("rand_count", n_out, 65);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
